// File: rtl/host_sequencer.sv
// rtl/host_sequencer.sv - host-side preload / run / read-back sequencer for the 9-bit core
module host_sequencer #(
    parameter int AW      = 8,
    parameter int TW      = 12,
    parameter int MAX_CYC = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW:0]   rd_count,
    input  logic          ld_valid,
    input  logic          ld_last,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic          cpu_rst,
    output logic          req,
    input  logic          done,
    output logic          res_valid,
    output logic [7:0]    res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_RUN,
        S_READ
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(MAX_CYC - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          res_valid_q, res_valid_d;
    logic          timeout_err_q, timeout_err_d;

    logic res_fire;
    logic run_timeout;

    assign res_fire    = res_valid_q && res_ready;
    assign run_timeout = (state_q == S_RUN) && !done && (cnt_q == CNT_LAST);

    // State register; reset aborts any session straight back to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done wins over the timeout on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: if (ld_valid && ld_last) state_d = S_REQ;
            S_REQ:  state_d = S_RUN;
            S_RUN: begin
                if (done) begin
                    state_d = S_READ;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                end else if (res_fire && (rem_q == (AW+1)'(1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: read window latched on start, run counter, sticky timeout flag
    always_comb begin
        ptr_d         = ptr_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d         = rd_base;
                    rem_d         = rd_count;
                    timeout_err_d = 1'b0;
                end
            end
            S_REQ: cnt_d = '0;
            S_RUN: begin
                cnt_d = cnt_q + TW'(1);
                if (run_timeout) timeout_err_d = 1'b1;
            end
            S_READ: begin
                if (res_fire) begin
                    ptr_d = ptr_q + AW'(1);
                    rem_d = rem_q - (AW+1)'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs are computed from the upcoming state so they align with it
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        req_d       = (state_d == S_REQ);
        res_valid_d = (state_d == S_READ) && (rem_d != '0);
        case (state_d)
            S_LOAD:               cpu_rst_d = 1'b1;
            S_REQ, S_RUN, S_READ: cpu_rst_d = 1'b0;
            default:              cpu_rst_d = run_timeout ? 1'b1 : cpu_rst_q;
        endcase
    end

    // Datapath and registered-output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            cpu_rst_q     <= 1'b1;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            cpu_rst_q     <= cpu_rst_d;
            req_q         <= req_d;
            busy_q        <= busy_d;
            res_valid_q   <= res_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Memory port is shared: preload writes in LOAD, read-back addressing in READ
    always_comb begin
        ld_ready    = (state_q == S_LOAD);
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = 8'h00;
        res_data    = 8'h00;
        if ((state_q == S_LOAD) && ld_valid) begin
            mem_wr_en   = 1'b1;
            mem_addr    = ld_addr;
            mem_wr_data = ld_data;
        end else if (res_valid_q) begin
            mem_addr = ptr_q;
            res_data = mem_rd_data;
        end
    end

    assign cpu_rst     = cpu_rst_q;
    assign req         = req_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_host_sequencer.sv
// tb/tb_host_sequencer.sv - directed self-checking bench for host_sequencer
module tb_host_sequencer;

    localparam int AW      = 8;
    localparam int TW      = 12;
    localparam int MAX_CYC = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rd_base;
    logic [AW:0]   rd_count;
    logic          ld_valid;
    logic          ld_last;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wr_data;
    logic [7:0]    mem_rd_data;
    logic          cpu_rst;
    logic          req;
    logic          done;
    logic          res_valid;
    logic [7:0]    res_data;
    logic          res_ready;
    logic          busy;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;
    int req_cnt  = 0;
    int xfer_cnt = 0;

    logic [7:0] mem [0:255];

    host_sequencer #(.AW(AW), .TW(TW), .MAX_CYC(MAX_CYC)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rd_base     (rd_base),
        .rd_count    (rd_count),
        .ld_valid    (ld_valid),
        .ld_last     (ld_last),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .cpu_rst     (cpu_rst),
        .req         (req),
        .done        (done),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Data memory model: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end
    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (req) req_cnt <= req_cnt + 1;
        if (res_valid && res_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_sess(input logic [7:0] base, input logic [8:0] cnt);
        start = 1'b1; rd_base = base; rd_count = cnt;
        #1;
        chk("idle_busy", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("load_busy", 32'(busy), 1);
        chk("load_cpu_rst", 32'(cpu_rst), 1);
        chk("load_ld_ready", 32'(ld_ready), 1);
    endtask

    task automatic load_beat(input logic [7:0] a, input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        #1;
        chk("ld_wr_en", 32'(mem_wr_en), 1);
        chk("ld_mem_addr", 32'(mem_addr), 32'(a));
        chk("ld_wr_data", 32'(mem_wr_data), 32'(d));
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // REQ cycle, then n RUN cycles with done low, then done high for one cycle
    task automatic req_run(input int n);
        int rv_hi;
        rv_hi = 0;
        #1;
        chk("req_high", 32'(req), 1);
        chk("req_cpu_rst", 32'(cpu_rst), 0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            #1;
            rv_hi += int'(res_valid) + int'(req);
            @(negedge clk);
        end
        done = 1'b1;
        #1;
        chk("run_no_valid_or_req", 32'(rv_hi + int'(res_valid)), 0);
        chk("run_busy", 32'(busy), 1);
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic read_word(input logic rdy, input logic [7:0] a, input logic [7:0] d);
        res_ready = rdy;
        #1;
        chk("rd_valid", 32'(res_valid), 1);
        chk("rd_addr", 32'(mem_addr), 32'(a));
        chk("rd_data", 32'(res_data), 32'(d));
        @(negedge clk);
    endtask

    initial begin
        int r0;
        int x0;
        int rv_hi;
        reset = 1'b0; start = 1'b0; rd_base = '0; rd_count = '0;
        ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
        done = 1'b0; res_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_req", 32'(req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wr_data", 32'(mem_wr_data), 0);
        chk("rst_res_data", 32'(res_data), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic session: done 50 cycles after req
        r0 = req_cnt;
        start_sess(8'h01, 9'd4);
        load_beat(8'h01, 8'h10, 1'b0);
        load_beat(8'h02, 8'h20, 1'b0);
        load_beat(8'h03, 8'h30, 1'b0);
        load_beat(8'h04, 8'h40, 1'b1);
        req_run(49);
        read_word(1'b1, 8'h01, 8'h10);
        read_word(1'b1, 8'h02, 8'h20);
        read_word(1'b1, 8'h03, 8'h30);
        read_word(1'b1, 8'h04, 8'h40);
        res_ready = 1'b0;
        #1;
        chk("basic_busy_end", 32'(busy), 0);
        chk("basic_valid_end", 32'(res_valid), 0);
        chk("basic_cpu_rst_end", 32'(cpu_rst), 0);
        chk("basic_req_pulses", 32'(req_cnt - r0), 1);
        @(negedge clk);

        // Backpressure: ready 1,0,0,1,0,1 over a 3-word window
        x0 = xfer_cnt;
        start_sess(8'h02, 9'd3);
        load_beat(8'h05, 8'h55, 1'b1);
        req_run(0);
        read_word(1'b1, 8'h02, 8'h20);
        read_word(1'b0, 8'h03, 8'h30);
        read_word(1'b0, 8'h03, 8'h30);
        read_word(1'b1, 8'h03, 8'h30);
        read_word(1'b0, 8'h04, 8'h40);
        read_word(1'b1, 8'h04, 8'h40);
        res_ready = 1'b0;
        #1;
        chk("bp_busy_end", 32'(busy), 0);
        chk("bp_xfers", 32'(xfer_cnt - x0), 3);
        @(negedge clk);

        // Address wrap across the top of memory
        start_sess(8'hFE, 9'd4);
        load_beat(8'hFE, 8'hA1, 1'b0);
        load_beat(8'hFF, 8'hA2, 1'b0);
        load_beat(8'h00, 8'hA3, 1'b0);
        load_beat(8'h01, 8'hA4, 1'b1);
        req_run(5);
        read_word(1'b1, 8'hFE, 8'hA1);
        read_word(1'b1, 8'hFF, 8'hA2);
        read_word(1'b1, 8'h00, 8'hA3);
        read_word(1'b1, 8'h01, 8'hA4);
        res_ready = 1'b0;
        #1;
        chk("wrap_busy_end", 32'(busy), 0);
        @(negedge clk);

        // Timeout: done never asserted
        start_sess(8'h09, 9'd2);
        load_beat(8'h09, 8'h99, 1'b1);
        #1;
        chk("to_req_high", 32'(req), 1);
        @(negedge clk);
        rv_hi = 0;
        for (int i = 0; i < MAX_CYC; i++) begin
            #1;
            rv_hi += int'(res_valid) + int'(timeout_err) + int'(!busy);
            @(negedge clk);
        end
        #1;
        chk("to_run_quiet", 32'(rv_hi), 0);
        chk("to_err_set", 32'(timeout_err), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_cpu_rst", 32'(cpu_rst), 1);
        chk("to_no_valid", 32'(res_valid), 0);
        @(negedge clk);
        #1;
        chk("to_err_sticky", 32'(timeout_err), 1);
        chk("to_cpu_rst_hold", 32'(cpu_rst), 1);
        @(negedge clk);

        // Next start clears the flag; done on the last allowed cycle wins; zero-length read
        start_sess(8'h20, 9'd0);
        chk("to_err_cleared", 32'(timeout_err), 0);
        load_beat(8'h40, 8'h5A, 1'b1);
        req_run(MAX_CYC - 1);
        #1;
        chk("late_done_read_busy", 32'(busy), 1);
        chk("late_done_no_err", 32'(timeout_err), 0);
        chk("zero_cnt_no_valid", 32'(res_valid), 0);
        @(negedge clk);
        #1;
        chk("zero_cnt_idle", 32'(busy), 0);
        chk("late_done_err_end", 32'(timeout_err), 0);
        @(negedge clk);

        // Reset mid-LOAD after 2 beats; the aborted third beat must not land
        start_sess(8'h20, 9'd2);
        load_beat(8'h20, 8'h31, 1'b0);
        load_beat(8'h21, 8'h32, 1'b0);
        ld_valid = 1'b1; ld_addr = 8'h21; ld_data = 8'h77; ld_last = 1'b0;
        #1;
        chk("mid_wr_en_before", 32'(mem_wr_en), 1);
        reset = 1'b0;
        #1;
        chk("mid_wr_en_drop", 32'(mem_wr_en), 0);
        chk("mid_ld_ready", 32'(ld_ready), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_cpu_rst", 32'(cpu_rst), 1);
        chk("mid_mem_addr", 32'(mem_addr), 0);
        chk("mid_wr_data", 32'(mem_wr_data), 0);
        @(negedge clk);
        ld_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        start_sess(8'h20, 9'd2);
        load_beat(8'h50, 8'h11, 1'b1);
        req_run(3);
        read_word(1'b1, 8'h20, 8'h31);
        read_word(1'b1, 8'h21, 8'h32);
        res_ready = 1'b0;
        #1;
        chk("post_rst_busy_end", 32'(busy), 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/host_sequencer.md
# host_sequencer

Host-side initiator for the 9-bit processor core. It drives the core's `req`/`done` handshake and reset from outside the core. Before a run it preloads words into the core's data memory through a shared write port. It holds the core in reset during preload, releases it, and waits for `done` or a cycle timeout. It then streams a contiguous window of data memory back out as results. It sits between the testbench/host and the processor top level and owns the data memory's external port.

## Interface
Parameters:
- `AW`, 8: data-memory address width
- `TW`, 12: timeout counter width
- `MAX_CYC`, 1024: cycles allowed between run start and `done` (must be < 2^TW)

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse that begins a session; sampled only in IDLE
- `rd_base` in AW: first read-back address; latched on accepted `start`
- `rd_count` in AW+1: number of read-back words, 0..2^AW; latched on accepted `start`
- `ld_valid` in 1: preload word available
- `ld_last` in 1: marks the final preload word
- `ld_addr` in AW: preload address
- `ld_data` in 8: preload data
- `ld_ready` out 1: preload word accepted this cycle when high together with `ld_valid`
- `mem_wr_en` out 1: data-memory write enable
- `mem_addr` out AW: data-memory address
- `mem_wr_data` out 8: data-memory write data
- `mem_rd_data` in 8: data-memory read data; combinational, same cycle as `mem_addr`
- `cpu_rst` out 1: active-high reset to the core
- `req` out 1: run request to the core
- `done` in 1: level completion flag from the core
- `res_valid` out 1: result word valid
- `res_data` out 8: result word
- `res_ready` in 1: consumer accepts the result word
- `busy` out 1: high in every state except IDLE
- `timeout_err` out 1: sticky error flag; cleared on the next accepted `start`

## Operation
States and transitions:
- IDLE: `start` latches `rd_base` and `rd_count`, clears `timeout_err`, and moves to LOAD.
- LOAD: `cpu_rst`=1 and `ld_ready`=1.
  - Each `ld_valid` beat drives `mem_wr_en`=1, `mem_addr`=`ld_addr` and `mem_wr_data`=`ld_data` combinationally in the same cycle.
  - A beat with `ld_last`=1 moves to REQ.
  - Zero preload words is not supported; a session needs at least one beat.
- REQ: `cpu_rst`=0 and `req`=1 for exactly one cycle. The timeout counter clears to 0. Moves to RUN.
- RUN: the counter increments each cycle.
  - `done`=1 moves to READ. `done` takes priority over timeout on the same cycle.
  - Counter reaching MAX_CYC-1 without `done` sets `timeout_err` and moves to IDLE, skipping read-back.
  - `cpu_rst`=1 is asserted on the IDLE entry that follows a timeout.
- READ: an internal pointer `ptr` starts at `rd_base` and a count `rem` starts at `rd_count`.
  - While `rem`≠0: `mem_addr`=`ptr`, `res_valid`=1 and `res_data`=`mem_rd_data`.
  - On each `res_valid`&`res_ready`: `ptr`+=1, wrapping mod 2^AW, and `rem`-=1.
  - `rem`=0 moves to IDLE. A `rd_count` of 0 passes through READ for one cycle with `res_valid`=0.
  - `res_data` stays stable while `res_valid`=1 and `res_ready`=0.
- `mem_wr_en`=0 outside LOAD. `ld_ready`=0 outside LOAD.
- `start` is ignored while `busy`=1.
- In IDLE, `cpu_rst` holds its last value: 1 after a timeout, 0 after a normal completion, so the core keeps its final state readable.

## Timing
- Reset values: state=IDLE, `cpu_rst`=1, `req`=0, `busy`=0, `timeout_err`=0, `res_valid`=0, `ld_ready`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `res_data`=0.
- Reset is asynchronous. Asserting it mid-session immediately aborts to IDLE with the values above. No partial write is committed after the assertion edge.
- `start` accepted at edge k: LOAD is active at cycle k+1.
- The `ld_last` beat accepted at edge n: REQ occupies cycle n+1, and `req` is high only during that cycle. RUN starts at n+2.
- Run cycle count: `done` sampled high at RUN cycle m gives READ at m+1, and the first `res_valid` appears in that same cycle.
- Throughput: one result per cycle when `res_ready` is held high. READ lasts max(`rd_count`,1) cycles.
- Timeout: with `done` never asserted, `timeout_err` rises exactly MAX_CYC cycles after RUN entry, and the state is IDLE the same cycle.
- All outputs are registered except `mem_wr_en`, `mem_addr`, `mem_wr_data`, `res_data` and `ld_ready`, which are combinational from state and inputs.

## Test plan
- Basic session: preload addr 1..4 with 0x10,0x20,0x30,0x40 (last on addr 4). Model `done` 50 cycles after `req`. `rd_base`=1, `rd_count`=4 -> `req` is a single 1-cycle pulse; `res_data` is 0x10,0x20,0x30,0x40; `busy` falls the cycle after the 4th handshake; `cpu_rst`=0 at the end.
- Backpressure: `rd_count`=3, `res_ready` toggled 1,0,0,1,0,1 -> exactly 3 transfers; `res_data` holds during stalls; no word is skipped or duplicated.
- Wrap: AW=8, `rd_base`=0xFE, `rd_count`=4 -> reads addresses FE, FF, 00, 01 in order.
- Timeout: MAX_CYC=16, `done` held 0 -> `timeout_err`=1 16 cycles after RUN entry; state IDLE; `cpu_rst`=1; no `res_valid`. The next `start` clears `timeout_err`.
- `done` on the timeout cycle: `done` rises on RUN cycle 15 with MAX_CYC=16 -> READ is entered and `timeout_err` stays 0.
- Reset mid-LOAD after 2 of 4 beats: `reset` pulsed low -> all outputs return to reset values asynchronously; `mem_wr_en` drops the same instant; `start` is accepted normally afterwards.
